nibble_serial_adder: RTL and testbench

- Sequences WIDTH-bit operand pairs through a 4-bit add datapath, one nibble per cycle, LSB nibble first.
- Carries between nibbles are held in a register, so wide additions reuse one 4-bit add slice.
- Sits between an operand source and a result consumer, with valid/ready handshakes on both sides.
- Produces the full WIDTH-bit sum, the unsigned carry-out, and a signed-overflow flag.

---
 rtl/nibble_serial_adder.sv | 106 ++++++++++
 tb/tb_nibble_serial_adder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Serial adder: WIDTH-bit operands summed one nibble per cycle through a single
// 4-bit add slice, with valid/ready handshakes on the operand and result sides.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic             cout_reg;
    logic             ovf_reg;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       t;
    logic             last;
    logic             accept;

    assign a_nib  = a_reg[{idx, 2'b00} +: 4];
    assign b_nib  = b_reg[{idx, 2'b00} +: 4];
    assign t      = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    assign last   = (idx == IDXW'(NIB - 1));

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign out_sum   = sum_reg;
    assign out_cout  = cout_reg;
    assign out_ovf   = ovf_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Carry into the top bit equals a^b^sum at that bit, so the overflow flag
    // falls out of the final slice without a separate 3-bit adder.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        carry <= in_cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum_reg[{idx, 2'b00} +: 4] <= t[3:0];
                    carry <= t[4];
                    idx   <= idx + IDXW'(1);
                    if (last) begin
                        cout_reg <= t[4];
                        ovf_reg  <= (a_nib[3] ^ b_nib[3] ^ t[3]) ^ t[4];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): vector table plus
// directed backpressure and mid-operation reset sequences.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    int tests_run  = 0;
    int tests_fail = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[8];

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand pair, waits for acceptance and then for out_valid;
    // returns the number of edges from acceptance to out_valid.
    task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        check_output("in_ready_before_op", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_output("out_valid_after_hs", {31'b0, out_valid}, 32'd0);
        check_output("in_ready_after_hs", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run_and_check(input vec_t v, input string tag);
        int lat;
        apply_stimulus(v.a, v.b, v.cin, lat);
        check_output({tag, "_latency"}, lat, 32'd4);
        check_output({tag, "_sum"}, {16'b0, out_sum}, {16'b0, v.exp_sum});
        check_output({tag, "_cout"}, {31'b0, out_cout}, {31'b0, v.exp_cout});
        check_output({tag, "_ovf"}, {31'b0, out_ovf}, {31'b0, v.exp_ovf});
        release_result();
    endtask

    initial begin
        int lat;
        logic [15:0] held_sum;
        logic        held_cout;
        logic        held_ovf;
        vec_t        v;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[5] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check_output("reset_in_ready", {31'b0, in_ready}, 32'd0);
        check_output("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("reset_sum", {16'b0, out_sum}, 32'd0);
        check_output("reset_cout", {31'b0, out_cout}, 32'd0);
        check_output("reset_ovf", {31'b0, out_ovf}, 32'd0);
        rst = 1'b0;
        #1;
        check_output("idle_in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_and_check(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held while new operands are offered.
        apply_stimulus(16'h0F0F, 16'h0101, 1'b0, lat);
        check_output("bp_latency", lat, 32'd4);
        held_sum  = 16'h1010;
        held_cout = 1'b0;
        held_ovf  = 1'b0;
        in_valid  = 1'b1;
        in_a      = 16'hAAAA;
        in_b      = 16'h5555;
        in_cin    = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_output("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check_output("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check_output("bp_sum", {16'b0, out_sum}, {16'b0, held_sum});
            check_output("bp_cout", {31'b0, out_cout}, {31'b0, held_cout});
            check_output("bp_ovf", {31'b0, out_ovf}, {31'b0, held_ovf});
        end
        in_valid = 1'b0;
        release_result();
        v = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
        run_and_check(v, "bp_next");

        // Reset asserted for one cycle while idx=2 in RUN.
        in_valid = 1'b1;
        in_a     = 16'hFFFF;
        in_b     = 16'h0001;
        in_cin   = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_output("midrst_in_ready_low", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_output("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        check_output("midrst_sum", {16'b0, out_sum}, 32'd0);
        check_output("midrst_cout", {31'b0, out_cout}, 32'd0);
        check_output("midrst_ovf", {31'b0, out_ovf}, 32'd0);
        for (int c = 0; c < 6; c++) begin
            tick();
            check_output("midrst_no_result", {31'b0, out_valid}, 32'd0);
        end
        v = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        run_and_check(v, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
